// File: rtl/uw_pkg.sv
// uw_pkg: definitions shared by the unique-word transmit framer and the
// receive-side correlator.
//   state_t        framer states
//   UW_*_DEF       default unique word, its length and the QPSK magnitude;
//                  both link ends take these from here so they agree
//   iq_t / qpsk_map  two-bit symbol to signed I/Q mapping
package uw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UW      = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int                 UW_LEN_DEF     = 16;
  localparam logic [31:0]        UW_PATTERN_DEF = 32'hE1B4_5A3C;
  localparam logic signed [15:0] AMP_DEF        = 16'sd8192;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_t;

  // bit 1 selects the I sign, bit 0 the Q sign; a set bit means negative
  function automatic iq_t qpsk_map(input logic [1:0] bits,
                                   input logic signed [15:0] amp);
    iq_t s;
    s.i = bits[1] ? -amp : amp;
    s.q = bits[0] ? -amp : amp;
    return s;
  endfunction

endpackage

// File: rtl/uw_symbol_rom.sv
// uw_symbol_rom: combinational lookup of unique-word symbol idx.
//   idx           symbol index, symbol 0 sits in the pattern MSBs
//   sym_i, sym_q  mapped QPSK constellation point
module uw_symbol_rom
  import uw_pkg::*;
#(
  parameter int                      UW_LEN     = UW_LEN_DEF,
  parameter logic [2*UW_LEN-1:0]     UW_PATTERN = UW_PATTERN_DEF,
  parameter logic signed [15:0]      AMP        = AMP_DEF,
  parameter int                      IW         = (UW_LEN > 1) ? $clog2(UW_LEN) : 1
) (
  input  logic [IW-1:0]      idx,
  output logic signed [15:0] sym_i,
  output logic signed [15:0] sym_q
);

  logic [2*UW_LEN-1:0] shifted;
  logic [1:0]          bits;
  iq_t                 sym;

  // shift the wanted symbol up into the top two bits
  always_comb begin
    shifted = UW_PATTERN << {idx, 1'b0};
    bits    = shifted[2*UW_LEN-1 -: 2];
    sym     = qpsk_map(bits, AMP);
    sym_i   = sym.i;
    sym_q   = sym.q;
  end

endmodule

// File: rtl/uw_frame_tx.sv
// uw_frame_tx: unique-word frame transmitter.
// Sends UW_LEN unique-word symbols, PAYLOAD_LEN samples pulled from a
// valid/ready source, then GAP_LEN zero samples, as a strobed I/Q stream.
//   clk, rst                 clock, synchronous active-high reset
//   start                    frame request, only honoured in IDLE
//   pl_valid, pl_i, pl_q     upstream payload sample
//   pl_ready                 payload accept (state PAYLOAD)
//   out_en, out_i, out_q     registered sample strobe and data
//   sof, eof                 first UW symbol / last payload sample markers
//   busy                     frame in progress
//
// state   | meaning
// IDLE    | waiting for start, outputs hold
// UW      | emitting unique-word symbol uw_cnt
// PAYLOAD | forwarding accepted payload beats, stalls while pl_valid=0
// GAP     | emitting zero samples
module uw_frame_tx
  import uw_pkg::*;
#(
  parameter int                  UW_LEN      = UW_LEN_DEF,
  parameter logic [2*UW_LEN-1:0] UW_PATTERN  = UW_PATTERN_DEF,
  parameter logic signed [15:0]  AMP         = AMP_DEF,
  parameter int                  PAYLOAD_LEN = 256,
  parameter int                  GAP_LEN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pl_valid,
  input  logic signed [15:0] pl_i,
  input  logic signed [15:0] pl_q,
  output logic               pl_ready,
  output logic               out_en,
  output logic signed [15:0] out_i,
  output logic signed [15:0] out_q,
  output logic               sof,
  output logic               eof,
  output logic               busy
);

  localparam int UW_CW  = (UW_LEN > 1)      ? $clog2(UW_LEN)      : 1;
  localparam int PL_CW  = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int GAP_CW = (GAP_LEN > 1)     ? $clog2(GAP_LEN)     : 1;

  localparam logic [UW_CW-1:0]  UW_LAST  = UW_CW'(UW_LEN - 1);
  localparam logic [PL_CW-1:0]  PL_LAST  = PL_CW'(PAYLOAD_LEN - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t              state_q, state_d;
  logic [UW_CW-1:0]    uw_cnt_q, uw_cnt_d;
  logic [PL_CW-1:0]    pl_cnt_q, pl_cnt_d;
  logic [GAP_CW-1:0]   gap_cnt_q, gap_cnt_d;
  logic                en_d, sof_d, eof_d;
  logic signed [15:0]  i_d, q_d;
  logic signed [15:0]  rom_i, rom_q;

  uw_symbol_rom #(
    .UW_LEN     (UW_LEN),
    .UW_PATTERN (UW_PATTERN),
    .AMP        (AMP),
    .IW         (UW_CW)
  ) u_rom (
    .idx   (uw_cnt_q),
    .sym_i (rom_i),
    .sym_q (rom_q)
  );

  // masked during reset so an upstream source never sees a beat taken in
  // the cycle the frame is aborted
  assign pl_ready = (state_q == PAYLOAD) && !rst;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    uw_cnt_d  = uw_cnt_q;
    pl_cnt_d  = pl_cnt_q;
    gap_cnt_d = gap_cnt_q;
    en_d      = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    i_d       = out_i;
    q_d       = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = UW;
          uw_cnt_d = '0;
        end
      end
      UW: begin
        en_d  = 1'b1;
        i_d   = rom_i;
        q_d   = rom_q;
        sof_d = (uw_cnt_q == '0);
        if (uw_cnt_q == UW_LAST) begin
          state_d  = PAYLOAD;
          uw_cnt_d = '0;
          pl_cnt_d = '0;
        end else begin
          uw_cnt_d = uw_cnt_q + 1'b1;
        end
      end
      PAYLOAD: begin
        if (pl_valid) begin
          en_d = 1'b1;
          i_d  = pl_i;
          q_d  = pl_q;
          if (pl_cnt_q == PL_LAST) begin
            eof_d     = 1'b1;
            pl_cnt_d  = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_LEN == 0) ? IDLE : GAP;
          end else begin
            pl_cnt_d = pl_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        en_d = 1'b1;
        i_d  = '0;
        q_d  = '0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      uw_cnt_q  <= '0;
      pl_cnt_q  <= '0;
      gap_cnt_q <= '0;
      out_en    <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      sof       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      state_q   <= state_d;
      uw_cnt_q  <= uw_cnt_d;
      pl_cnt_q  <= pl_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_en    <= en_d;
      out_i     <= i_d;
      out_q     <= q_d;
      sof       <= sof_d;
      eof       <= eof_d;
    end
  end

endmodule

// File: tb/tb_uw_frame_tx.sv
// tb_uw_frame_tx: randomized bench for uw_frame_tx. Expected sample stream is
// built per frame from the unique-word mapping rule, the payload list handed
// to the source, and the gap length.
module tb_uw_frame_tx;
  import uw_pkg::*;

  localparam int UW_N   = 16;
  localparam int PL_N   = 256;
  localparam int GAP_N  = 4;
  localparam int FRAME  = UW_N + PL_N + GAP_N;
  localparam int AMP_I  = 8192;
  localparam logic [31:0] PAT = 32'hE1B4_5A3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1, start = 1'b0;
  logic               pl_valid = 1'b0;
  logic signed [15:0] pl_i = '0, pl_q = '0;
  logic               pl_ready, out_en, sof, eof, busy;
  logic signed [15:0] out_i, out_q;

  logic               s_start = 1'b0;
  logic               s_ready, s_en, s_sof, s_eof, s_busy;
  logic signed [15:0] s_oi, s_oq;

  uw_frame_tx dut (
    .clk(clk), .rst(rst), .start(start), .pl_valid(pl_valid), .pl_i(pl_i),
    .pl_q(pl_q), .pl_ready(pl_ready), .out_en(out_en), .out_i(out_i),
    .out_q(out_q), .sof(sof), .eof(eof), .busy(busy)
  );

  uw_frame_tx #(.PAYLOAD_LEN(1), .GAP_LEN(0)) dut_short (
    .clk(clk), .rst(rst), .start(s_start), .pl_valid(1'b1),
    .pl_i(16'sh1234), .pl_q(-16'sd5), .pl_ready(s_ready), .out_en(s_en),
    .out_i(s_oi), .out_q(s_oq), .sof(s_sof), .eof(s_eof), .busy(s_busy)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [33:0] exp_q[$];       // {sof, eof, i, q}
  logic [31:0] src_q[$];       // {i, q} payload the source offers in order
  int          src_idx = 0;
  bit          src_rand = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  bit          acc_pend = 0;

  task automatic push_frame(input int n, input bit ramp);
    logic [1:0]         b;
    logic signed [15:0] si, sq;
    logic [31:0]        v;
    for (int k = 0; k < UW_N; k++) begin
      b  = 2'((PAT >> (2 * (UW_N - 1 - k))) & 32'd3);
      si = (b >= 2) ? 16'(-AMP_I) : 16'(AMP_I);
      sq = (b % 2 == 1) ? 16'(-AMP_I) : 16'(AMP_I);
      exp_q.push_back({k == 0, 1'b0, si, sq});
    end
    for (int j = 0; j < n; j++) begin
      v = ramp ? {16'(j), 16'(-j)} : $urandom;
      src_q.push_back(v);
      exp_q.push_back({1'b0, j == n - 1, v});
    end
    for (int g = 0; g < GAP_N; g++) exp_q.push_back(34'd0);
  endtask

  // ---------------- payload source ----------------
  always begin
    logic v;
    @(negedge clk);
    #1;
    if (acc_pend) src_idx++;
    if (stall_left > 0) begin
      v = 1'b0;
      stall_left--;
    end else if (src_idx == stall_at) begin
      stall_at   = -1;
      stall_left = 4;
      v          = 1'b0;
    end else begin
      v = (src_idx < src_q.size()) && (!src_rand || $urandom_range(0, 2) != 0);
    end
    pl_valid = v;
    if (v) {pl_i, pl_q} = src_q[src_idx];
    else   {pl_i, pl_q} = $urandom;
    acc_pend = v && pl_ready && !rst;
  end

  // ---------------- output monitor ----------------
  bit                 mon_on = 0, rst_d = 1, seen_sof = 0;
  logic signed [15:0] last_i = '0, last_q = '0;
  int                 run = 0, zeros = 0, last_run = 0, last_gap = 0, holes = 0, sof_cnt = 0;
  int                 runs_q[$];

  always begin
    logic [33:0] e;
    @(negedge clk);
    #2;
    if (mon_on) begin
      if (rst_d) begin
        check("rst_en", out_en, 0);
        check("rst_iq", {out_i, out_q}, 0);
        check("rst_sof_eof", {sof, eof}, 0);
        check("rst_busy_ready", {busy, pl_ready}, 0);
        exp_q.delete();
        last_i = '0; last_q = '0;
        run = 0; zeros = 0;
      end else if (out_en) begin
        if (run == 0) last_gap = zeros;
        run++;
        zeros = 0;
        if (sof) begin seen_sof = 1; sof_cnt++; end
        if (exp_q.size() == 0) begin
          check("extra_sample", {sof, eof, out_i, out_q}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sample", {sof, eof, out_i, out_q}, e);
          last_i = e[31:16];
          last_q = e[15:0];
        end
      end else begin
        check("hold", {out_i, out_q}, {last_i, last_q});
        if (run > 0) begin
          last_run = run;
          runs_q.push_back(run);
          run = 0;
        end
        zeros++;
        if (seen_sof && busy) holes++;
      end
    end
    rst_d = rst;
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #3;
    check("pre_sof_en", out_en, 0);
    check("busy_after_start", busy, 1);
    @(negedge clk); #3;
    check("sof_latency", {out_en, sof}, 2'b11);
    check("ready_in_uw", pl_ready, 0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #3;
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
    @(negedge clk); #3;
  endtask

  task automatic wait_src(input int target);
    for (int k = 0; k < 3000 && src_idx < target; k++) @(negedge clk);
    check("src_progress", src_idx >= target, 1);
  endtask

  task automatic new_frame_stats();
    holes = 0; seen_sof = 0; runs_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sh_en, sh_sof_at, sh_eof_at, sh_cyc;
    logic signed [15:0] sh_eof_i;

    @(negedge clk); @(negedge clk);
    mon_on = 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full ramp frame, with an ignored start pulse mid-payload
    new_frame_stats();
    push_frame(PL_N, 1);
    pulse_start();
    wait_src(50);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    check("frame_len", last_run, FRAME);
    check("frame_sofs", sof_cnt, 1);
    repeat (20) @(negedge clk);
    #3;
    check("no_restart", busy, 0);
    check("ramp_drained", exp_q.size(), 0);

    // five-cycle stall mid-payload
    new_frame_stats();
    stall_at = src_q.size() + 100;
    push_frame(PL_N, 0);
    pulse_start();
    wait_idle();
    check("stall_holes", holes, 5);
    check("stall_drained", exp_q.size(), 0);

    // random valid pattern
    new_frame_stats();
    src_rand = 1;
    push_frame(PL_N, 0);
    pulse_start();
    wait_idle();
    src_rand = 0;
    check("rand_drained", exp_q.size(), 0);

    // start held high: two back-to-back frames
    new_frame_stats();
    sof_cnt = 0;
    push_frame(PL_N, 0);
    push_frame(PL_N, 0);
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 2000 && sof_cnt < 2; k++) @(negedge clk);
    start = 1'b0;
    check("second_sof", sof_cnt, 2);
    check("interframe_gap", last_gap, 1);
    wait_idle();
    check("b2b_runs", runs_q.size(), 2);
    if (runs_q.size() == 2) begin
      check("b2b_run0", runs_q[0], FRAME);
      check("b2b_run1", runs_q[1], FRAME);
    end
    check("b2b_drained", exp_q.size(), 0);

    // reset mid-payload, then a clean frame
    new_frame_stats();
    push_frame(PL_N, 0);
    pulse_start();
    wait_src(src_q.size() - PL_N + 100);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    src_q.delete(); src_idx = 0; stall_at = -1;
    #3;
    check("rst_ignores_start", busy, 0);
    repeat (3) @(negedge clk);
    new_frame_stats();
    push_frame(PL_N, 1);
    pulse_start();
    wait_idle();
    check("post_rst_len", last_run, FRAME);
    check("post_rst_drained", exp_q.size(), 0);

    // short configuration: 1 payload sample, no gap
    sh_en = 0; sh_sof_at = -1; sh_eof_at = -1; sh_eof_i = '0; sh_cyc = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk); #3;
      if (s_en) begin
        if (s_sof) sh_sof_at = sh_en;
        if (s_eof) begin sh_eof_at = sh_en; sh_eof_i = s_oi; end
        sh_en++;
        sh_cyc = k;
      end
    end
    check("short_len", sh_en, UW_N + 1);
    check("short_sof_pos", sh_sof_at, 0);
    check("short_eof_pos", sh_eof_at, UW_N);
    check("short_eof_data", sh_eof_i, 16'sh1234);
    check("short_contig", sh_cyc, UW_N);
    check("short_idle", {s_busy, s_en}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
